// File: rtl/mult_pkg.sv
// Shared limits and elaboration-time helpers for the streaming pipelined multiplier.
package mult_pkg;

  localparam int MAX_STAGES = 8;
  localparam int MAX_W      = 32;

  function automatic int slice_w(input int b_w, input int stages);
    if (stages < 1) return b_w;
    return b_w / stages;
  endfunction

  function automatic bit params_legal(input int a_w, input int b_w,
                                      input int stages, input int tag_w);
    if (a_w < 2 || a_w > MAX_W) return 1'b0;
    if (b_w < 2 || b_w > MAX_W) return 1'b0;
    if (stages < 1 || stages > MAX_STAGES) return 1'b0;
    if ((b_w % stages) != 0) return 1'b0;
    if (tag_w < 1) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/mult_pp_stage.sv
// One multiplier pipeline stage: adds the partial product of the lowest remaining
// b slice into the running accumulator and forwards the beat's sideband.
module mult_pp_stage
  import mult_pkg::*;
#(
  parameter int A_W    = 16,
  parameter int B_W    = 16,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4,
  parameter int IDX    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               prev_valid,
  input  logic [A_W+B_W:0]   prev_acc,
  input  logic [A_W:0]       prev_a,
  input  logic [B_W-1:0]     prev_b,
  input  logic               prev_sgn,
  input  logic [TAG_W-1:0]   prev_tag,
  output logic               valid,
  output logic [A_W+B_W:0]   acc,
  output logic [A_W:0]       a,
  output logic [B_W-1:0]     b,
  output logic               sgn,
  output logic [TAG_W-1:0]   tag
);

  localparam int SW     = slice_w(B_W, STAGES);
  localparam int ACC_W  = A_W + B_W + 1;
  localparam int SHIFT  = IDX * SW;
  localparam bit IS_TOP = (IDX == STAGES - 1);

  logic [SW-1:0]    slice;
  logic             ext_bit;
  logic [ACC_W-1:0] a_wide;
  logic [ACC_W-1:0] b_wide;
  logic [ACC_W-1:0] pp;
  logic [ACC_W-1:0] acc_next;

  // Only the most significant b slice carries negative weight for signed beats;
  // everything is extended to the accumulator width so modular adds are exact.
  always_comb begin
    slice    = prev_b[SW-1:0];
    ext_bit  = IS_TOP && prev_sgn && slice[SW-1];
    a_wide   = {{B_W{prev_a[A_W]}}, prev_a};
    b_wide   = {{(ACC_W-SW){ext_bit}}, slice};
    pp       = (a_wide * b_wide) << SHIFT;
    acc_next = prev_acc + pp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      acc   <= '0;
      a     <= '0;
      b     <= '0;
      sgn   <= 1'b0;
      tag   <= '0;
    end else if (en) begin
      valid <= prev_valid;
      acc   <= acc_next;
      a     <= prev_a;
      b     <= prev_b >> SW;
      sgn   <= prev_sgn;
      tag   <= prev_tag;
    end
  end

endmodule

// File: rtl/pipe_mult_stream.sv
// Fully pipelined A_W x B_W multiplier with valid/ready streaming, per-beat
// signed/unsigned mode and a tag that travels with each product.
module pipe_mult_stream
  import mult_pkg::*;
#(
  parameter int A_W    = 16,
  parameter int B_W    = 16,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       in_a,
  input  logic [B_W-1:0]       in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_W+B_W-1:0]   out_y,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           occupancy
);

  localparam int ACC_W = A_W + B_W + 1;

  if (!params_legal(A_W, B_W, STAGES, TAG_W)) begin : g_param_err
    $error("pipe_mult_stream: illegal A_W/B_W/STAGES/TAG_W combination");
  end

  logic             adv;
  logic             v_pipe   [STAGES+1];
  logic [ACC_W-1:0] acc_pipe [STAGES+1];
  logic [A_W:0]     a_pipe   [STAGES+1];
  logic [B_W-1:0]   b_pipe   [STAGES+1];
  logic             s_pipe   [STAGES+1];
  logic [TAG_W-1:0] t_pipe   [STAGES+1];
  logic             unused_tail;

  // The whole pipe moves as one; a held output freezes every stage, bubbles included.
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv && !rst;

  assign v_pipe[0]   = in_valid;
  assign acc_pipe[0] = '0;
  assign a_pipe[0]   = {in_signed & in_a[A_W-1], in_a};
  assign b_pipe[0]   = in_b;
  assign s_pipe[0]   = in_signed;
  assign t_pipe[0]   = in_tag;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mult_pp_stage #(
      .A_W    (A_W),
      .B_W    (B_W),
      .STAGES (STAGES),
      .TAG_W  (TAG_W),
      .IDX    (k)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .en         (adv),
      .prev_valid (v_pipe[k]),
      .prev_acc   (acc_pipe[k]),
      .prev_a     (a_pipe[k]),
      .prev_b     (b_pipe[k]),
      .prev_sgn   (s_pipe[k]),
      .prev_tag   (t_pipe[k]),
      .valid      (v_pipe[k+1]),
      .acc        (acc_pipe[k+1]),
      .a          (a_pipe[k+1]),
      .b          (b_pipe[k+1]),
      .sgn        (s_pipe[k+1]),
      .tag        (t_pipe[k+1])
    );
  end

  assign out_valid = v_pipe[STAGES];
  assign out_y     = acc_pipe[STAGES][A_W+B_W-1:0];
  assign out_tag   = t_pipe[STAGES];

  always_comb begin
    occupancy = '0;
    for (int k = 1; k <= STAGES; k++) begin
      occupancy = occupancy + 4'(v_pipe[k]);
    end
  end

  assign unused_tail = ^{acc_pipe[STAGES][ACC_W-1], a_pipe[STAGES], b_pipe[STAGES], s_pipe[STAGES]};

endmodule

// File: tb/tb_pipe_mult_stream.sv
// Directed-vector and scoreboard bench for pipe_mult_stream, plus a small
// latency sweep over narrow configurations.
module tb_pipe_mult_stream;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_signed;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [3:0]  out_tag;
  logic [3:0]  occupancy;

  logic        s_valid;
  logic [7:0]  s_a;
  logic [11:0] s_b;
  logic        s_sgn;
  logic [3:0]  s_tag;
  logic        s_out_ready;
  logic        sw_rdy [3];
  logic        sw_ov  [3];
  logic [19:0] sw_y   [3];
  logic [3:0]  sw_tag [3];
  logic [3:0]  sw_occ [3];

  int checks;
  int failures;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [3:0]  tag;
    logic [31:0] y;
  } vec_t;

  typedef struct packed {
    logic [31:0] y;
    logic [3:0]  tag;
  } res_t;

  vec_t vecs [12];
  res_t acc_q [$];
  res_t del_q [$];

  pipe_mult_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .occupancy (occupancy)
  );

  function automatic int st_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 6);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    pipe_mult_stream #(
      .A_W    (8),
      .B_W    (12),
      .STAGES ((g == 0) ? 1 : ((g == 1) ? 3 : 6)),
      .TAG_W  (4)
    ) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_valid),
      .in_ready  (sw_rdy[g]),
      .in_a      (s_a),
      .in_b      (s_b),
      .in_signed (s_sgn),
      .in_tag    (s_tag),
      .out_valid (sw_ov[g]),
      .out_ready (s_out_ready),
      .out_y     (sw_y[g]),
      .out_tag   (sw_tag[g]),
      .occupancy (sw_occ[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
    longint sa;
    longint sb;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    return 32'(sa * sb);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_q.push_back({ref_mul(in_a, in_b, in_signed), in_tag});
      if (out_valid && out_ready) del_q.push_back({out_y, out_tag});
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [3:0] t);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = t;
  endtask

  task automatic sweep_run(input string name, input logic [7:0] a, input logic [11:0] b,
                           input logic s, input logic [19:0] exp_y);
    int          lat  [3];
    logic [19:0] ys   [3];
    logic [3:0]  tg   [3];
    for (int g = 0; g < 3; g++) begin
      lat[g] = -1;
      ys[g]  = '0;
      tg[g]  = '0;
      chk($sformatf("%s_ready_%0d", name, g), 64'(sw_rdy[g]), 64'd1);
    end
    s_a = a; s_b = b; s_sgn = s; s_tag = 4'd5; s_valid = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      step();
      s_valid = 1'b0;
      if (t == 1) begin
        for (int g = 0; g < 3; g++) chk($sformatf("%s_occ_%0d", name, g), 64'(sw_occ[g]), 64'd1);
      end
      for (int g = 0; g < 3; g++) begin
        if (sw_ov[g] && lat[g] < 0) begin
          lat[g] = t;
          ys[g]  = sw_y[g];
          tg[g]  = sw_tag[g];
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_lat_st%0d", name, st_of(g)), 64'(lat[g]), 64'(st_of(g)));
      chk($sformatf("%s_y_st%0d", name, st_of(g)), 64'(ys[g]), 64'(exp_y));
      chk($sformatf("%s_tag_st%0d", name, st_of(g)), 64'(tg[g]), 64'd5);
    end
  endtask

  initial begin
    logic [31:0] bp_exp [5];
    checks   = 0;
    failures = 0;

    vecs[0]  = '{16'd3,     16'd7,     1'b0, 4'd1,  32'd21};
    vecs[1]  = '{16'd12,    16'd9,     1'b0, 4'd2,  32'd108};
    vecs[2]  = '{16'hFFFF,  16'd2,     1'b0, 4'd3,  32'd131070};
    vecs[3]  = '{16'hFFFF,  16'hFFFF,  1'b0, 4'd4,  32'hFFFE0001};
    vecs[4]  = '{16'h8000,  16'h8000,  1'b1, 4'd5,  32'h40000000};
    vecs[5]  = '{16'hFFFF,  16'd5,     1'b1, 4'd6,  32'hFFFFFFFB};
    vecs[6]  = '{16'h8000,  16'd1,     1'b0, 4'd7,  32'h00008000};
    vecs[7]  = '{16'h7FFF,  16'h8000,  1'b1, 4'd8,  32'hC0008000};
    vecs[8]  = '{16'hFFFF,  16'h8000,  1'b0, 4'd9,  32'h7FFF8000};
    vecs[9]  = '{16'hFFFF,  16'hFFFF,  1'b1, 4'd10, 32'h00000001};
    vecs[10] = '{16'h1234,  16'h0000,  1'b1, 4'd11, 32'h00000000};
    vecs[11] = '{16'h8000,  16'hFFFF,  1'b1, 4'd12, 32'h00008000};

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0);
    s_valid = 1'b0; s_a = '0; s_b = '0; s_sgn = 1'b0; s_tag = '0; s_out_ready = 1'b1;

    // reset state
    step(); step();
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_y",     64'(out_y),     64'd0);
    chk("rst_out_tag",   64'(out_tag),   64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    step();

    // back-to-back directed vectors, out_ready held high
    for (int t = 0; t < 12 + 5; t++) begin
      if (t < 12) drive(1'b1, vecs[t].a, vecs[t].b, vecs[t].sgn, vecs[t].tag);
      else        drive(1'b0, '0, '0, 1'b0, '0);
      if (t == 3) begin
        chk("tbl_not_early", 64'(out_valid), 64'd0);
        chk("tbl_occ_fill",  64'(occupancy), 64'd3);
      end
      if (t == 6) chk("tbl_occ_full", 64'(occupancy), 64'd4);
      if (t >= 4 && t - 4 < 12) begin
        chk($sformatf("tbl_valid_%0d", t - 4), 64'(out_valid), 64'd1);
        chk($sformatf("tbl_y_%0d", t - 4),     64'(out_y),     64'(vecs[t-4].y));
        chk($sformatf("tbl_tag_%0d", t - 4),   64'(out_tag),   64'(vecs[t-4].tag));
      end
      step();
    end
    repeat (3) step();
    chk("tbl_drained_occ", 64'(occupancy), 64'd0);

    // backpressure: fill four beats while the consumer stalls
    del_q.delete();
    for (int i = 0; i < 5; i++) bp_exp[i] = 32'((i + 1) * (100 + i));
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(i + 1), 16'(100 + i), 1'b0, 4'(i + 3));
      step();
    end
    drive(1'b1, 16'd5, 16'd104, 1'b0, 4'd7);
    chk("bp_occ_full",  64'(occupancy), 64'd4);
    chk("bp_in_ready",  64'(in_ready),  64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_y_head",    64'(out_y),     64'(bp_exp[0]));
    repeat (3) step();
    chk("bp_y_stable",   64'(out_y),     64'(bp_exp[0]));
    chk("bp_tag_stable", 64'(out_tag),   64'd3);
    chk("bp_occ_stable", 64'(occupancy), 64'd4);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    #1;
    chk("bp_one_occ",   64'(occupancy),   64'd4);
    chk("bp_one_y",     64'(out_y),       64'(bp_exp[1]));
    chk("bp_one_tag",   64'(out_tag),     64'd4);
    chk("bp_one_count", 64'(del_q.size()), 64'd1);
    repeat (2) step();
    chk("bp_hold_count", 64'(del_q.size()), 64'd1);
    out_ready = 1'b1;
    repeat (6) step();
    chk("bp_total", 64'(del_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < del_q.size(); i++) begin
      chk($sformatf("bp_order_y_%0d", i),   64'(del_q[i].y),   64'(bp_exp[i]));
      chk($sformatf("bp_order_tag_%0d", i), 64'(del_q[i].tag), 64'(i + 3));
    end

    // random valid/ready against the scoreboard
    acc_q.delete();
    del_q.delete();
    for (int c = 0; c < 40000 && acc_q.size() < 10000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_a      = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
      in_b      = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
      in_signed = 1'($urandom);
      in_tag    = 4'($urandom_range(15));
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    out_ready = 1'b1;
    repeat (10) step();
    chk("rand_beats",     64'(acc_q.size()), 64'd10000);
    chk("rand_delivered", 64'(del_q.size()), 64'(acc_q.size()));
    for (int i = 0; i < acc_q.size() && i < del_q.size(); i++) begin
      chk($sformatf("rand_beat_%0d", i), 64'(del_q[i]), 64'(acc_q[i]));
    end

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(7 + i), 16'd11, 1'b0, 4'(i + 1));
      step();
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_occ",       64'(occupancy), 64'd0);
    chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
    drive(1'b1, 16'd5, 16'd5, 1'b0, 4'd9);
    for (int t = 1; t <= 4; t++) begin
      step();
      drive(1'b0, '0, '0, 1'b0, '0);
      if (t < 4) chk($sformatf("post_rst_quiet_%0d", t), 64'(out_valid), 64'd0);
    end
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_y",     64'(out_y),     64'd25);
    chk("post_rst_tag",   64'(out_tag),   64'd9);
    step();

    // narrow configurations: latency tracks STAGES
    sweep_run("sw_u", 8'd255, 12'd4095, 1'b0, 20'd1044225);
    sweep_run("sw_s", 8'h80,  12'h800,  1'b1, 20'h40000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
